// File: rtl/axis_pkt_source.sv
// axis_pkt_source: AXI-Stream packet generator. Each accepted command
// produces len+1 beats whose data follows one of four patterns derived
// from the command seed. Completed packets are pulsed on pkt_done and
// counted on pkt_cnt.
module axis_pkt_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic                  cmd_tid,
    input  logic [1:0]            cmd_cfg,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  m_tid,
    output logic [1:0]            m_cfg,
    output logic                  pkt_done,
    output logic [15:0]           pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [LEN_WIDTH-1:0]  idx_nxt;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [DATA_WIDTH-1:0] offs;
    logic                  tlast_q;
    logic                  tid_q;
    logic [1:0]            cfg_q;
    logic                  done_q;
    logic [15:0]           cnt_q;
    logic                  accept;
    logic                  xfer;
    logic                  last_xfer;

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus command-accept and beat-transfer strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        xfer      = 1'b0;
        last_xfer = 1'b0;
        case (state)
            IDLE: begin
                accept = cmd_valid;
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                xfer      = m_tready;
                last_xfer = m_tready & tlast_q;
                if (last_xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data for the beat following the current one (index idx_q+1).
    always_comb begin
        idx_nxt  = idx_q + LEN_WIDTH'(1);
        offs     = DATA_WIDTH'(idx_nxt);
        data_nxt = seed_q;
        case (cfg_q)
            2'b00:   data_nxt = seed_q + offs;
            2'b01:   data_nxt = seed_q - offs;
            2'b10:   data_nxt = seed_q;
            default: data_nxt = idx_nxt[0] ? ~seed_q : seed_q;
        endcase
    end

    // Command latch and registered beat datapath; every pattern starts at seed.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            len_q   <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
            tid_q   <= 1'b0;
            cfg_q   <= 2'b00;
        end else if (accept) begin
            len_q   <= cmd_len;
            seed_q  <= cmd_seed;
            idx_q   <= '0;
            tdata_q <= cmd_seed;
            tlast_q <= (cmd_len == '0);
            tid_q   <= cmd_tid;
            cfg_q   <= cmd_cfg;
        end else if (xfer && !tlast_q) begin
            idx_q   <= idx_nxt;
            tdata_q <= data_nxt;
            tlast_q <= (idx_nxt == len_q);
        end else if (last_xfer) begin
            tlast_q <= 1'b0;
        end
    end

    // Completion pulse and wrapping packet counter.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= last_xfer;
            if (last_xfer) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign cmd_ready = (state == IDLE) & nrst;
    assign m_tvalid  = (state == SEND);
    assign m_tdata   = tdata_q;
    assign m_tlast   = tlast_q;
    assign m_tid     = tid_q;
    assign m_cfg     = cfg_q;
    assign pkt_done  = done_q;
    assign pkt_cnt   = cnt_q;

endmodule
